// File: rtl/spi_cfg_master.sv
// SPI write-frame master: round-robin arbitration between two requesters,
// serialising {1, addr[6:0], data[7:0]} MSB first onto SCLK/nCS/COPI.
module spi_cfg_master #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       SCLK,
  output logic       nCS,
  output logic       COPI,
  output logic       busy,
  output logic       err_addr
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_BIT_HI, S_BIT_LO, S_GAP} state_t;

  state_t        state;
  logic          prio1;      // 1: req1 wins a tie (req0 was served last)
  logic [14:0]   shreg;
  logic [3:0]    bit_idx;
  logic          last;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          idle;
  logic          xfer;
  logic [6:0]    sel_addr;
  logic [7:0]    sel_data;

  assign idle       = (state == S_IDLE);
  assign req0_ready = rst_n && idle && req0_valid && (!req1_valid || !prio1);
  assign req1_ready = rst_n && idle && req1_valid && (!req0_valid ||  prio1);
  assign xfer       = req0_ready || req1_ready;
  assign sel_addr   = req1_ready ? req1_addr : req0_addr;
  assign sel_data   = req1_ready ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prio1    <= 1'b0;
      shreg    <= '0;
      bit_idx  <= 4'd0;
      last     <= 1'b0;
      cnt      <= '0;
      gcnt     <= '0;
      SCLK     <= 1'b0;
      nCS      <= 1'b1;
      COPI     <= 1'b0;
      busy     <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= 1'b0;
      case (state)
        S_IDLE: if (xfer) begin
          prio1   <= req0_ready;
          shreg   <= {sel_addr, sel_data};
          bit_idx <= 4'd15;
          last    <= 1'b0;
          cnt     <= '0;
          // Out-of-range writes are consumed but never reach the wire
          if (sel_addr > 7'h04) begin
            err_addr <= 1'b1;
          end else begin
            state <= S_SETUP;
            busy  <= 1'b1;
            nCS   <= 1'b0;
            COPI  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= S_BIT_HI;
            SCLK  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= S_BIT_LO;
            SCLK  <= 1'b0;
            // After bit 0 the low phase is only a hold time
            if (bit_idx == 4'd0) begin
              COPI <= 1'b0;
              last <= 1'b1;
            end else begin
              COPI    <= shreg[14];
              shreg   <= {shreg[13:0], 1'b0};
              bit_idx <= bit_idx - 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIT_LO: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (last) begin
              nCS   <= 1'b1;
              gcnt  <= '0;
              state <= S_GAP;
            end else begin
              SCLK  <= 1'b1;
              state <= S_BIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_MAX) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_cfg_master.md
# spi_cfg_master

SPI write-frame master that configures the chip's SPI register peripheral (output enables 0x00–0x01, PWM enables 0x02–0x03, PWM duty 0x04) from on-chip logic. Two internal requesters share the single SPI link through a round-robin arbiter. The block serialises each accepted write into the peripheral's 16-bit frame format and drives SCLK/nCS/COPI. Frame timing is slow enough for the peripheral's 2-FF synchronisers and edge detect.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range ≥4.
- GAP, 4, clk cycles nCS held high after each frame; legal range ≥4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  7  requester 0 register address.
- req0_data  input  8  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready: same as requester 0.
- SCLK  output  1  SPI clock, idle low.
- nCS  output  1  SPI chip select, active low.
- COPI  output  1  SPI data to peripheral, MSB first.
- busy  output  1  high whenever state ≠ IDLE.
- err_addr  output  1  one-cycle pulse: accepted write had address > 0x04.

## Operation
- States: IDLE, SETUP, BIT_HI, BIT_LO, GAP.
- Arbitration (IDLE only): if one valid, it wins; if both valid, the requester not served last wins. After reset, req0 has priority.
- reqN_ready is combinational: high only in IDLE, for the arbitration winner, while its valid is high. A transfer occurs when valid && ready. Pointer updates on every transfer.
- On transfer, latch word = {1'b1, addr[6:0], data[7:0]} and a bit index of 15.
- Address > 0x04: no frame is sent. err_addr pulses the next cycle and the state stays IDLE. The arbiter pointer still updates.
- Valid address sequence:
  - IDLE → SETUP: nCS=0, SCLK=0, COPI=word[15].
  - SETUP (CLK_DIV cycles) → BIT_HI.
  - BIT_HI: SCLK=1 for CLK_DIV cycles → BIT_LO.
  - BIT_LO: SCLK=0 and COPI=next bit, both updated on the same clk edge, for CLK_DIV cycles.
  - After bit 0 the BIT_LO phase acts as hold and COPI=0. nCS is then released → GAP (GAP cycles, nCS=1) → IDLE.
- Requests are sampled only in IDLE. Valid while busy is ignored and ready stays low. Address and data must stay stable until ready.
- Read frames (bit15=0) are never generated.

## Timing
- All SPI outputs and busy/err_addr are registered.
- Reset values: nCS=1, SCLK=0, COPI=0, busy=0, err_addr=0, ready=0, state=IDLE, pointer→req0.
- Reset mid-frame: outputs return to reset values asynchronously. The peripheral sees an nCS rise with fewer than 16 bits and discards the frame.
- Latency: nCS falls 1 cycle after the transfer. The first SCLK rise comes CLK_DIV cycles later.
- Frame timing:
  - nCS is low for 33·CLK_DIV cycles (132 at CLK_DIV=4).
  - There are exactly 16 SCLK rising edges.
  - COPI is stable for CLK_DIV cycles before and during each SCLK high phase.
- Back-to-back frames: next-transfer-to-transfer period = 33·CLK_DIV + GAP + 1 cycles.
- Simultaneous valid on both requesters in the same IDLE cycle: exactly one ready is asserted.
- Counters: half-period counter is ⌈log2(CLK_DIV)⌉ bits and wraps to 0 at each phase end. Bit index is 4 bits and stops at 0, with no wrap.

## Test plan
- req0 writes addr 0x04, data 0xA5 (CLK_DIV=4, GAP=4):
  - COPI sampled at SCLK rises = 1000_0100_1010_0101.
  - nCS low 132 cycles.
  - Peripheral model pwm_duty_cycle=0xA5.
  - busy drops 137 cycles after the transfer.
- Both valid from reset, each holding 2 writes (addr 0x00/0x01) → service order is req0, req1, req0, req1. Each transfer shows exactly one ready.
- req1 writes addr 0x05, data 0xFF → req1_ready=1, err_addr pulses one cycle later, nCS stays 1, no SCLK edges, peripheral registers unchanged.
- rst_n low after 8 SCLK rises of an addr 0x00, data 0x3C write:
  - nCS=1, SCLK=0, COPI=0 before the next clk edge.
  - Peripheral en_reg_out_7_0 remains 0x00.
- req0_valid raised mid-frame → req0_ready stays 0 until IDLE. The write is accepted in the first IDLE cycle, and nCS was high for ≥GAP cycles between the frames.
- CLK_DIV=6, 10 random valid writes → peripheral model registers match the last value written to each address.
